// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg: screen geometry, colour constants and pixel-sink FSM states |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vga_pkg;

    localparam int XSCREEN = 640;
    localparam int YSCREEN = 480;
    localparam int COLOR_W = 9;
    localparam int ADDR_W  = 19;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = 9'b000_000_000;
    localparam logic [COLOR_W-1:0] COLOR_RED   = 9'b111_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } sink_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: first-word-fall-through FIFO, push accepted when full if  |
// | a pop happens in the same cycle.  Rev 1.0                            |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_write_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_write_sink: registers client pixel strobes, bounds-checks and  |
// | queues them for video memory; also fills the screen on request.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pixel_write_sink #(
    parameter int XSCREEN    = vga_pkg::XSCREEN,
    parameter int YSCREEN    = vga_pkg::YSCREEN,
    parameter int COLOR_W    = vga_pkg::COLOR_W,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic [9:0]                  VGA_x,
    input  logic [8:0]                  VGA_y,
    input  logic [COLOR_W-1:0]          VGA_color,
    input  logic                        VGA_write,
    input  logic                        clear_req,
    input  logic [COLOR_W-1:0]          clear_color,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [COLOR_W-1:0]          mem_data,
    output logic                        mem_we,
    input  logic                        mem_ready,
    output logic                        clearing,
    output logic                        clear_done,
    output logic                        dropped,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    import vga_pkg::*;

    localparam int                ENTRY_W  = ADDR_W + COLOR_W;
    localparam logic [9:0]        X_LIM    = 10'(XSCREEN);
    localparam logic [8:0]        Y_LIM    = 9'(YSCREEN);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(XSCREEN * YSCREEN - 1);

    logic               in_vld_q;
    logic [9:0]         in_x_q;
    logic [8:0]         in_y_q;
    logic [COLOR_W-1:0] in_color_q;

    logic               dropped_q;
    logic               overflow_q;
    logic               clr_req_q;
    logic [COLOR_W-1:0] clr_color_q, clr_color_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    sink_state_e        state_q, state_d;

    logic               in_range;
    logic               push_req;
    logic               pop;
    logic               clr_rise;
    logic [ADDR_W-1:0]  pix_addr;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            in_vld_q   <= 1'b0;
            in_x_q     <= '0;
            in_y_q     <= '0;
            in_color_q <= '0;
        end else begin
            in_vld_q   <= VGA_write;
            in_x_q     <= VGA_x;
            in_y_q     <= VGA_y;
            in_color_q <= VGA_color;
        end
    end

    // y*640 + x as two shifts; the widened operands keep every carry.
    assign in_range = (in_x_q < X_LIM) && (in_y_q < Y_LIM);
    assign push_req = in_vld_q && in_range;
    assign pix_addr = (ADDR_W'(in_y_q) << 9) + (ADDR_W'(in_y_q) << 7) + ADDR_W'(in_x_q);
    assign clr_rise = clear_req && !clr_req_q;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .push_i  (push_req),
        .data_i  ({pix_addr, in_color_q}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            dropped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (in_vld_q && !in_range) begin
                dropped_q <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign dropped  = dropped_q;
    assign overflow = overflow_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clr_color_q <= COLOR_W'(COLOR_BLACK);
            clr_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_color_q <= clr_color_d;
            clr_req_q   <= clear_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_color_d = clr_color_q;
        pop         = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;
        clearing    = 1'b0;
        clear_done  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DRAIN: begin
                mem_we = !fifo_empty;
                pop    = !fifo_empty && mem_ready;
                if (!fifo_empty) begin
                    mem_addr = head[ENTRY_W-1:COLOR_W];
                    mem_data = head[COLOR_W-1:0];
                end
                if (state_q == ST_IDLE) begin
                    if (clr_rise) begin
                        state_d     = ST_DRAIN;
                        clr_color_d = clear_color;
                    end
                end else if (fifo_empty && !push_req) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                end
            end
            // Client pixels keep queueing here but the port belongs to the fill.
            ST_FILL: begin
                clearing = 1'b1;
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                mem_data = clr_color_q;
                if (mem_ready) begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                clear_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pixel_write_sink: directed and random pixel streams checked       |
// | against a queue model of the frame-buffer write port. Rev 1.0        |
// +----------------------------------------------------------------------+
module tb_pixel_write_sink;
    import vga_pkg::*;

    localparam int XS  = 640;
    localparam int YS  = 480;
    localparam int SXS = 32;
    localparam int SYS = 16;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [9:0]  VGA_x = '0;
    logic [8:0]  VGA_y = '0;
    logic [8:0]  VGA_color = '0;
    logic        VGA_write = 1'b0;
    logic        clear_req = 1'b0;
    logic        clear_req_s = 1'b0;
    logic [8:0]  clear_color = '0;
    logic        mem_ready = 1'b0;

    logic [18:0] mem_addr, s_mem_addr;
    logic [8:0]  mem_data, s_mem_data;
    logic        mem_we, s_mem_we, clearing, s_clearing, clear_done, s_clear_done;
    logic        dropped, s_dropped, overflow, s_overflow;
    logic [4:0]  fifo_level, s_fifo_level;

    pixel_write_sink dut (
        .Clock(Clock), .Resetn(Resetn), .VGA_x(VGA_x), .VGA_y(VGA_y),
        .VGA_color(VGA_color), .VGA_write(VGA_write), .clear_req(clear_req),
        .clear_color(clear_color), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_ready(mem_ready), .clearing(clearing),
        .clear_done(clear_done), .dropped(dropped), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    // Reduced screen so a complete fill fits in a short run.
    pixel_write_sink #(.XSCREEN(SXS), .YSCREEN(SYS)) dut_s (
        .Clock(Clock), .Resetn(Resetn), .VGA_x(VGA_x), .VGA_y(VGA_y),
        .VGA_color(VGA_color), .VGA_write(VGA_write), .clear_req(clear_req_s),
        .clear_color(clear_color), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .mem_we(s_mem_we), .mem_ready(mem_ready), .clearing(s_clearing),
        .clear_done(s_clear_done), .dropped(s_dropped), .overflow(s_overflow),
        .fifo_level(s_fifo_level)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    logic [27:0] got[$];
    logic [27:0] got_s[$];
    logic [27:0] exp_q[$];
    int          done_pulses = 0;
    int          done_pulses_s = 0;
    int          fill_acc_s = 0;
    logic        prev_stall = 1'b0;
    logic [27:0] prev_word = '0;

    // Write-port monitor: records accepted writes, checks stall stability.
    always @(negedge Clock) begin
        if (!Resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {mem_we, mem_addr, mem_data}, {1'b1, prev_word});
            if (mem_we && mem_ready) got.push_back({mem_addr, mem_data});
            if (s_mem_we && mem_ready) got_s.push_back({s_mem_addr, s_mem_data});
            if (s_clearing && s_mem_we && mem_ready) fill_acc_s++;
            if (clear_done) done_pulses++;
            if (s_clear_done) done_pulses_s++;
            prev_stall = mem_we && !mem_ready;
            prev_word  = {mem_addr, mem_data};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] model_word(input int x, input int y, input logic [8:0] c);
        int a;
        a = y * 640 + x;
        return {a[18:0], c};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0; VGA_write = 1'b0; clear_req = 1'b0; clear_req_s = 1'b0; mem_ready = 1'b0;
        tick(2);
        Resetn = 1'b1;
        tick(1);
        got.delete(); got_s.delete(); exp_q.delete();
        done_pulses = 0; done_pulses_s = 0; fill_acc_s = 0;
    endtask

    task automatic drive_pix(input int x, input int y, input logic [8:0] c);
        VGA_x = 10'(x); VGA_y = 9'(y); VGA_color = c; VGA_write = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        tick(2);
        while ((fifo_level != 0 || mem_we) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) chk("drain_timeout", fifo_level, 0);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    endtask

    logic [8:0] c;
    int         x, y, len, k, bad;
    logic       exp_drop;

    initial begin
        // Reset state
        do_reset();
        @(negedge Clock);
        chk("reset_mem", {mem_we, mem_addr, mem_data}, 0);
        chk("reset_flags", {clearing, clear_done, dropped, overflow}, 0);
        chk("reset_level", fifo_level, 0);
        tick();

        // Single pixel latency: launched after edge N, mem_we after N+2
        mem_ready = 1'b1;
        drive_pix(10, 2, 9'h1C0);
        tick();
        VGA_write = 1'b0;
        @(negedge Clock); chk("lat_we_n1", mem_we, 0);
        @(negedge Clock); chk("lat_we_n2", mem_we, 1);
        chk("lat_addr", mem_addr, 1290);
        chk("lat_data", mem_data, 9'h1C0);
        @(negedge Clock); chk("lat_we_n3", mem_we, 0);
        tick();
        chk("single_count", got.size(), 1);
        chk("single_nodrop", dropped, 0);

        // Bounds
        do_reset();
        mem_ready = 1'b1;
        drive_pix(639, 479, 9'h0AB); tick();
        drive_pix(640, 0, 9'h111);   tick();
        drive_pix(0, 480, 9'h122);   tick();
        VGA_write = 1'b0;
        wait_idle();
        exp_q.push_back({19'd307199, 9'h0AB});
        cmp_stream("bounds");
        chk("bounds_dropped", dropped, 1);
        chk("bounds_overflow", overflow, 0);

        // Backpressure: 40 strobes into a stalled port
        do_reset();
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(0, XS - 1); y = $urandom_range(0, YS - 1); c = 9'($urandom);
            drive_pix(x, y, c);
            if (i < 16) exp_q.push_back(model_word(x, y, c));
            tick();
        end
        VGA_write = 1'b0;
        tick(2);
        chk("bp_level", fifo_level, 16);
        chk("bp_overflow", overflow, 1);
        chk("bp_no_writes", got.size(), 0);
        mem_ready = 1'b1;
        wait_idle();
        cmp_stream("bp");

        // Stall hold with mem_ready alternating
        do_reset();
        for (int i = 0; i < 40; i++) begin
            mem_ready = (i % 2 == 0);
            if (i < 8) begin
                x = $urandom_range(0, XS - 1); y = $urandom_range(0, YS - 1); c = 9'($urandom);
                drive_pix(x, y, c);
                exp_q.push_back(model_word(x, y, c));
            end else begin
                VGA_write = 1'b0;
            end
            tick();
        end
        mem_ready = 1'b1;
        wait_idle();
        cmp_stream("toggle");
        chk("toggle_overflow", overflow, 0);

        // Random strobes, some out of range, port always ready
        do_reset();
        mem_ready = 1'b1;
        exp_drop = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                x = $urandom_range(0, 700); y = $urandom_range(0, 511); c = 9'($urandom);
                drive_pix(x, y, c);
                if (x < XS && y < YS) exp_q.push_back(model_word(x, y, c));
                else exp_drop = 1'b1;
            end else begin
                VGA_write = 1'b0;
            end
            tick();
        end
        VGA_write = 1'b0;
        wait_idle();
        cmp_stream("rand_a");
        chk("rand_a_dropped", dropped, exp_drop);
        chk("rand_a_overflow", overflow, 0);

        // Random bursts of at most FIFO depth with random backpressure
        do_reset();
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                x = $urandom_range(0, XS - 1); y = $urandom_range(0, YS - 1); c = 9'($urandom);
                drive_pix(x, y, c);
                exp_q.push_back(model_word(x, y, c));
                mem_ready = 1'($urandom_range(0, 1));
                tick();
            end
            VGA_write = 1'b0;
            repeat (20) begin
                mem_ready = 1'($urandom_range(0, 1));
                tick();
            end
            mem_ready = 1'b1;
            wait_idle();
        end
        cmp_stream("rand_b");
        chk("rand_b_overflow", overflow, 0);

        // Full clear on the reduced screen, with 3 pixels queued ahead of it
        do_reset();
        exp_q.delete();
        drive_pix(3, 1, 9'h155);  tick();
        drive_pix(31, 15, 9'h0F0); tick();
        drive_pix(0, 0, 9'h00F);  tick();
        VGA_write = 1'b0;
        tick(2);
        clear_color = COLOR_RED;
        clear_req_s = 1'b1;
        tick();
        clear_color = COLOR_BLACK;
        tick(2);
        mem_ready = 1'b1;
        k = 0;
        while (done_pulses_s == 0 && k < 2000) begin
            if (k == 100) clear_req_s = 1'b0;
            if (k == 101) clear_req_s = 1'b1;
            tick();
            k++;
        end
        tick(20);
        chk("clear_done_pulses", done_pulses_s, 1);
        chk("clear_total", got_s.size(), 3 + SXS * SYS);
        chk("clear_fill_acc", fill_acc_s, SXS * SYS);
        chk("clear_after", {s_clearing, s_clear_done, s_mem_we}, 0);
        if (got_s.size() == 3 + SXS * SYS) begin
            chk("clear_pix0", got_s[0], model_word(3, 1, 9'h155));
            chk("clear_pix1", got_s[1], model_word(31, 15, 9'h0F0));
            chk("clear_pix2", got_s[2], model_word(0, 0, 9'h00F));
            bad = 0;
            for (int i = 0; i < SXS * SYS; i++)
                if (got_s[3 + i] !== {19'(i), COLOR_RED}) bad++;
            chk("clear_seq_errors", bad, 0);
        end

        // Reset in the middle of a full-size fill at counter 1000
        do_reset();
        mem_ready = 1'b1;
        clear_color = 9'h1FF;
        clear_req = 1'b1;
        k = 0;
        @(negedge Clock);
        while (!(clearing && mem_addr == 19'd999) && k < 1200) begin
            @(negedge Clock);
            k++;
        end
        chk("fill_reached_999", mem_addr, 999);
        chk("fill_data", mem_data, 9'h1FF);
        @(posedge Clock); #1;
        Resetn = 1'b0; clear_req = 1'b0; mem_ready = 1'b0;
        @(negedge Clock);
        chk("fill_at_1000", {clearing, mem_addr}, {1'b1, 19'd1000});
        @(posedge Clock); #1;
        Resetn = 1'b1;
        @(negedge Clock);
        chk("midfill_reset_mem", {mem_we, mem_addr, mem_data}, 0);
        chk("midfill_reset_flags", {clearing, clear_done, dropped, overflow, fifo_level}, 0);
        tick(4);
        chk("midfill_no_done", done_pulses, 0);
        got.delete(); exp_q.delete();
        mem_ready = 1'b1;
        drive_pix(5, 7, 9'h0C3); tick();
        VGA_write = 1'b0;
        exp_q.push_back(model_word(5, 7, 9'h0C3));
        wait_idle();
        cmp_stream("post_reset_idle");
        chk("post_reset_clearing", clearing, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
